// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// seg_pkg : shared constants, segment patterns and FSM encoding for the
//           multiplexed 7-segment display controller.
// Rev 1.0
// ============================================================================
package seg_pkg;

   localparam int unsigned BIN_W   = 14;
   localparam int unsigned BCD_W   = 16;
   localparam int unsigned BCD_MAX = 9999;

   // Segment patterns are active-low, ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [5:0] SEL_NONE = 6'b111111;
   localparam logic [5:0] SEL_THOU = 6'b011111;
   localparam logic [5:0] SEL_HUND = 6'b101111;
   localparam logic [5:0] SEL_TENS = 6'b110111;
   localparam logic [5:0] SEL_UNIT = 6'b111011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_LOAD = 2'd2
   } state_t;

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      case (digit)
         4'd0:    seg_encode = 7'b1000000;
         4'd1:    seg_encode = 7'b1111001;
         4'd2:    seg_encode = 7'b0100100;
         4'd3:    seg_encode = 7'b0110000;
         4'd4:    seg_encode = 7'b0011001;
         4'd5:    seg_encode = 7'b0010010;
         4'd6:    seg_encode = 7'b0000010;
         4'd7:    seg_encode = 7'b1111000;
         4'd8:    seg_encode = 7'b0000000;
         4'd9:    seg_encode = 7'b0010000;
         default: seg_encode = SEG_BLANK;
      endcase
   endfunction

   function automatic logic [5:0] seg_select(input logic [1:0] idx);
      case (idx)
         2'd0:    seg_select = SEL_THOU;
         2'd1:    seg_select = SEL_HUND;
         2'd2:    seg_select = SEL_TENS;
         default: seg_select = SEL_UNIT;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg_bin2bcd.sv
`default_nettype none
// ============================================================================
// seg_bin2bcd : iterative 14-bit double-dabble converter, one iteration per
//               clock, 14-cycle latency from i_start to a valid o_bcd.
// Rev 1.0
// ============================================================================
module seg_bin2bcd
   import seg_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [BIN_W-1:0] i_bin,
   output logic             o_done,
   output logic [BCD_W-1:0] o_bcd
);

   logic [BIN_W-1:0] r_bin;
   logic [BCD_W-1:0] r_bcd;
   logic [3:0]       r_cnt;
   logic             r_busy;
   logic [BCD_W-1:0] w_adj;

   for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                            : r_bcd[gi*4 +: 4];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= 4'd0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_bin  <= i_bin;
         r_bcd  <= '0;
         r_cnt  <= 4'(BIN_W);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
         r_cnt          <= r_cnt - 4'd1;
         if (r_cnt == 4'd1) begin
            r_busy <= 1'b0;
         end
      end
   end

   // High during the final iteration; o_bcd holds the full result next cycle
   assign o_done = r_busy && (r_cnt == 4'd1);
   assign o_bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/seg_disp_ctrl.sv
`default_nettype none
// ============================================================================
// seg_disp_ctrl : handshake-fed binary-to-BCD display controller with a
//                 tear-free commit and programmable per-digit dwell scan.
//                 Optional SEG_BLANK_LZ_EN blanks leading zero digits.
// Rev 1.0
// ============================================================================
module seg_disp_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned DWELL_CYC = 50000
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BIN_W-1:0] in_value,
   output logic             ovf,
   output logic [5:0]       seg_sel,
   output logic [6:0]       seg_data
);

   localparam int unsigned       DW_W     = 21;
   localparam logic [DW_W-1:0]   DWELL_TC = DW_W'(DWELL_CYC - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_in_ready;
   logic             r_ovf_pend;
   logic             r_ovf;
   logic             w_accept;
   logic             w_load;
   logic             w_conv_done;
   logic [BCD_W-1:0] w_bcd;
   logic [3:0]       w_lz;
   logic [3:0]       w_nib [4];
   logic [6:0]       w_pat [4];
   logic [6:0]       r_digit [4];

   logic [DW_W-1:0]  r_dwell;
   logic [1:0]       r_idx;
   logic             r_adv;
   logic             w_dwell_tc;
   logic [5:0]       r_seg_sel;
   logic [6:0]       r_seg_data;

   assign w_accept = in_valid && r_in_ready;

   seg_bin2bcd u_bin2bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_accept),
      .i_bin   (in_value),
      .o_done  (w_conv_done),
      .o_bcd   (w_bcd)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_in_ready <= 1'b0;
         r_ovf_pend <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt == ST_IDLE);
         if (w_accept) begin
            r_ovf_pend <= (in_value > BIN_W'(BCD_MAX));
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      unique case (r_state)
         ST_IDLE: if (w_accept)    w_state_nxt = ST_CONV;
         ST_CONV: if (w_conv_done) w_state_nxt = ST_LOAD;
         ST_LOAD: begin
            w_load      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Index 0 is the thousands digit, so it takes the top nibble
   for (genvar gi = 0; gi < 4; gi++) begin : g_enc
      assign w_nib[gi] = w_bcd[(3-gi)*4 +: 4];
      assign w_pat[gi] = r_ovf_pend ? SEG_DASH :
                         w_lz[gi]   ? SEG_BLANK : seg_encode(w_nib[gi]);
   end

`ifdef SEG_BLANK_LZ_EN
   assign w_lz[0] = (w_nib[0] == 4'd0);
   assign w_lz[1] = w_lz[0] && (w_nib[1] == 4'd0);
   assign w_lz[2] = w_lz[1] && (w_nib[2] == 4'd0);
   assign w_lz[3] = 1'b0;
`else
   assign w_lz = 4'b0000;
`endif

   // All four digits are committed together in LOAD to avoid tearing
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_digit[i] <= SEG_BLANK;
         end
         r_ovf <= 1'b0;
      end else if (w_load) begin
         for (int i = 0; i < 4; i++) begin
            r_digit[i] <= w_pat[i];
         end
         r_ovf <= r_ovf_pend;
      end
   end

   assign w_dwell_tc = (r_dwell == DWELL_TC);

   // r_adv resets high so the first digit is presented right after reset;
   // afterwards the output pair reloads only in the cycle after an index step
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dwell    <= '0;
         r_idx      <= 2'd0;
         r_adv      <= 1'b1;
         r_seg_sel  <= SEL_NONE;
         r_seg_data <= SEG_BLANK;
      end else begin
         r_adv <= w_dwell_tc;
         if (w_dwell_tc) begin
            r_dwell <= '0;
            r_idx   <= r_idx + 2'd1;
         end else begin
            r_dwell <= r_dwell + DW_W'(1);
         end
         if (r_adv) begin
            r_seg_sel  <= seg_select(r_idx);
            r_seg_data <= r_digit[r_idx];
         end
      end
   end

   assign in_ready = r_in_ready;
   assign ovf      = r_ovf;
   assign seg_sel  = r_seg_sel;
   assign seg_data = r_seg_data;

endmodule
`default_nettype wire

// File: tb/tb_seg_disp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_seg_disp_ctrl : self-checking bench, table vectors plus a cycle-timeline
//                    reference model; two instances (dwell 4 and dwell 1).
// Rev 1.0
// ============================================================================
module tb_seg_disp_ctrl;

   localparam int D_A = 4;
   localparam int D_B = 1;
`ifdef SEG_BLANK_LZ_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};
   localparam logic [6:0] BLK = 7'b1111111;
   localparam logic [6:0] DSH = 7'b0111111;
   localparam logic [5:0] SELS [4] = '{6'b011111, 6'b101111, 6'b110111, 6'b111011};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [13:0] in_value = 14'd0;
   logic        a_ready, a_ovf, b_ready, b_ovf;
   logic [5:0]  a_sel, b_sel;
   logic [6:0]  a_data, b_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seg_disp_ctrl #(.DWELL_CYC(D_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
      .in_value(in_value), .ovf(a_ovf), .seg_sel(a_sel), .seg_data(a_data));

   seg_disp_ctrl #(.DWELL_CYC(D_B)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready),
      .in_value(in_value), .ovf(b_ovf), .seg_sel(b_sel), .seg_data(b_data));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: a timeline of committed frames ----------
   typedef struct { int eff; logic [27:0] pats; logic ovf; } commit_t;
   commit_t commits[$];
   int      k = 0;
   int      busy_end = -1;
   logic    rst_smp = 1'b0;
   logic    started = 1'b0;

   function automatic logic [27:0] model_pats(input int v);
      int         d [4];
      logic       lead;
      logic [27:0] p;
      logic [6:0] s;
      if (v > 9999) return {DSH, DSH, DSH, DSH};
      d[0] = v / 1000; d[1] = (v / 100) % 10; d[2] = (v / 10) % 10; d[3] = v % 10;
      lead = 1'b1;
      p = '0;
      for (int i = 0; i < 4; i++) begin
         lead = lead && (d[i] == 0) && (i < 3);
         s = (LZ && lead) ? BLK : PAT[d[i]];
         p[27-7*i -: 7] = s;
      end
      return p;
   endfunction

   // Outputs reload at cycles that are multiples of the dwell, from the
   // frame that was committed before that reload cycle.
   function automatic logic [6:0] exp_data(input int kk, input int dd);
      int         j, idx;
      logic [6:0] r;
      j   = (kk / dd) * dd;
      idx = (kk / dd) % 4;
      r   = BLK;
      foreach (commits[n]) if (commits[n].eff <= j - 1) r = commits[n].pats[27-7*idx -: 7];
      return r;
   endfunction

   function automatic logic exp_ovf(input int kk);
      logic r;
      r = 1'b0;
      foreach (commits[n]) if (commits[n].eff <= kk) r = commits[n].ovf;
      return r;
   endfunction

   initial forever begin
      @(posedge clk);
      rst_smp = rst_n;
      started = 1'b1;
   end

   initial begin : p_model
      logic    exp_rdy;
      commit_t c;
      forever begin
         @(negedge clk);
         if (started) begin
            if (!rst_smp) begin
               chk("reset_a", {a_sel, a_data, a_ready, a_ovf}, {6'h3f, 7'h7f, 1'b0, 1'b0});
               chk("reset_b", {b_sel, b_data, b_ready, b_ovf}, {6'h3f, 7'h7f, 1'b0, 1'b0});
               k = 0;
               busy_end = -1;
               commits.delete();
            end else begin
               exp_rdy = (k > busy_end);
               chk("model_a {sel,data,ready,ovf}", {a_sel, a_data, a_ready, a_ovf},
                   {SELS[(k/D_A)%4], exp_data(k, D_A), exp_rdy, exp_ovf(k)});
               chk("model_b {sel,data,ready,ovf}", {b_sel, b_data, b_ready, b_ovf},
                   {SELS[(k/D_B)%4], exp_data(k, D_B), exp_rdy, exp_ovf(k)});
               if (in_valid && exp_rdy) begin
                  c.eff  = k + 16;
                  c.pats = model_pats(int'(in_value));
                  c.ovf  = (in_value > 14'd9999);
                  commits.push_back(c);
                  busy_end = k + 15;
               end
               k++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!a_ready && n < 60) begin
         tick();
         n++;
      end
      if (!a_ready) begin
         checks++;
         errors++;
         $display("FAIL %s: in_ready stayed 0 for 60 cycles, required 1", name);
      end
   endtask

   task automatic send(input logic [13:0] v);
      wait_ready("send_wait");
      in_valid = 1'b1;
      in_value = v;
      tick();
      in_valid = 1'b0;
      in_value = 14'($urandom_range(0, 16383));
   endtask

   task automatic capture(output logic [27:0] cap);
      cap = '0;
      for (int c = 0; c < 4 * D_A; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) if (a_sel == SELS[i]) cap[27-7*i -: 7] = a_data;
      end
      tick();
   endtask

   typedef struct { int value; logic [27:0] exp; logic ovf; } vec_t;
   localparam int NV = 8;
   vec_t vecs [NV];

   initial begin : p_main
      logic [27:0] cap;

      vecs[0] = '{1234,  {PAT[1], PAT[2], PAT[3], PAT[4]}, 1'b0};
      vecs[1] = '{12000, {DSH, DSH, DSH, DSH},             1'b1};
      vecs[2] = '{9999,  {PAT[9], PAT[9], PAT[9], PAT[9]}, 1'b0};
      vecs[3] = '{10000, {DSH, DSH, DSH, DSH},             1'b1};
      vecs[4] = '{16383, {DSH, DSH, DSH, DSH},             1'b1};
`ifdef SEG_BLANK_LZ_EN
      vecs[5] = '{42,    {BLK, BLK, PAT[4], PAT[2]},       1'b0};
      vecs[6] = '{0,     {BLK, BLK, BLK, PAT[0]},          1'b0};
      vecs[7] = '{705,   {BLK, PAT[7], PAT[0], PAT[5]},    1'b0};
`else
      vecs[5] = '{42,    {PAT[0], PAT[0], PAT[4], PAT[2]}, 1'b0};
      vecs[6] = '{0,     {PAT[0], PAT[0], PAT[0], PAT[0]}, 1'b0};
      vecs[7] = '{705,   {PAT[0], PAT[7], PAT[0], PAT[5]}, 1'b0};
`endif

      // Reset and idle scan
      repeat (3) tick();
      chk("ready_in_reset", a_ready, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("ready_after_reset", a_ready, 1'b1);
      for (int c = 0; c < 16; c++) begin
         chk($sformatf("idle_sel_a_c%0d", c), a_sel, SELS[c/4]);
         chk($sformatf("idle_sel_b_c%0d", c), b_sel, SELS[c%4]);
         chk($sformatf("idle_data_c%0d", c), a_data, BLK);
         tick();
      end

      // Table vectors: full frame captured after each commit
      for (int v = 0; v < NV; v++) begin
         send(14'(vecs[v].value));
         repeat (40) tick();
         capture(cap);
         for (int i = 0; i < 4; i++)
            chk($sformatf("vec%0d_digit%0d", vecs[v].value, i), cap[27-7*i -: 7], vecs[v].exp[27-7*i -: 7]);
         chk($sformatf("vec%0d_ovf", vecs[v].value), a_ovf, vecs[v].ovf);
      end

      // in_valid held high: 5 then 7, second handshake exactly 16 cycles later
      wait_ready("held_wait");
      in_valid = 1'b1;
      in_value = 14'd5;
      tick();
      in_value = 14'd7;
      for (int c = 1; c <= 15; c++) begin
         chk($sformatf("held_ready_T+%0d", c), a_ready, 1'b0);
         tick();
      end
      chk("held_ready_T+16", a_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      repeat (40) tick();
      capture(cap);
      chk("held_final", cap, model_pats(7));

      // Randomized traffic, including busy-time value churn
      for (int c = 0; c < 800; c++) begin
         in_valid = ($urandom_range(0, 4) == 0);
         case ($urandom_range(0, 5))
            0:       in_value = 14'd0;
            1:       in_value = 14'd9999;
            2:       in_value = 14'd10000;
            3:       in_value = 14'd16383;
            default: in_value = 14'($urandom_range(0, 16383));
         endcase
         tick();
      end
      in_valid = 1'b0;
      repeat (40) tick();

      // Reset in the middle of a conversion
      send(14'd8888);
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      chk("midreset_a", {a_sel, a_data, a_ready}, {6'h3f, 7'h7f, 1'b0});
      chk("midreset_b", {b_sel, b_data, b_ready}, {6'h3f, 7'h7f, 1'b0});
      rst_n = 1'b1;
      repeat (60) tick();
      capture(cap);
      chk("midreset_blank", cap, {BLK, BLK, BLK, BLK});
      chk("midreset_ovf", a_ovf, 1'b0);

      repeat (5) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
